// File: rtl/flagstore_pkg.sv
// Shared CPU definitions: condition-flag count, flag indices and the flag vector type.
package cpu_pkg;

  localparam int unsigned NUM_FLAGS = 4;

  // Index 0 is the leftmost bit of a 4'b literal.
  localparam int unsigned FLAG_EQ = 0;
  localparam int unsigned FLAG_LT = 1;
  localparam int unsigned FLAG_CF = 2;
  localparam int unsigned FLAG_OF = 3;

  typedef logic [0:NUM_FLAGS-1] flags_t;

endpackage

// File: rtl/flagstore_if.sv
// Execute-stage to flag-register bus: masked flag writes in, stored flags out.
interface flagstore_if;
  import cpu_pkg::*;

  flags_t flag_mask;
  flags_t new_flags;
  logic   eq;
  logic   lt;
  logic   cf;
  logic   of;

  // Execute stage drives writes and observes stored flags.
  modport master (
    output flag_mask,
    output new_flags,
    input  eq,
    input  lt,
    input  cf,
    input  of
  );

  // Flag register accepts writes and presents stored flags.
  modport slave (
    input  flag_mask,
    input  new_flags,
    output eq,
    output lt,
    output cf,
    output of
  );

endinterface

// File: rtl/flagstore_flag_bit.sv
// One condition flag: enable-gated flop with synchronous active-high clear.
module flag_bit (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);

  // Clear wins over enable; a disabled bit never samples d, so X on d cannot enter.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/flagstore.sv
// Four-bit CPU condition-flag register with per-flag write mask.
module flagstore
  import cpu_pkg::*;
(
  input logic        clk,
  input logic        nrst,
  flagstore_if.slave bus
);

  flags_t flags_q;

  // One independent flop per flag; no cross-flag logic.
  for (genvar i = 0; i < NUM_FLAGS; i++) begin : g_flag
    flag_bit u_flag_bit (
      .clk (clk),
      .rst (nrst),
      .en  (bus.flag_mask[i]),
      .d   (bus.new_flags[i]),
      .q   (flags_q[i])
    );
  end

  // Named outputs come straight from the flops.
  assign bus.eq = flags_q[FLAG_EQ];
  assign bus.lt = flags_q[FLAG_LT];
  assign bus.cf = flags_q[FLAG_CF];
  assign bus.of = flags_q[FLAG_OF];

  // An unknown mask bit leaves that flag unspecified; catch the caller error in simulation.
  mask_known_a : assert property (
    @(posedge clk) disable iff (nrst) !$isunknown(bus.flag_mask)
  );

  // Reset clears every flag regardless of mask and data.
  reset_clears_a : assert property (
    @(posedge clk) nrst |=> (flags_q == flags_t'(0))
  );

endmodule

// File: tb/tb_flagstore.sv
// Directed bench for flagstore with a masked-merge reference model and per-cycle compare.
module tb_flagstore;
  import cpu_pkg::*;

  logic clk;
  logic nrst;

  flagstore_if bus ();

  flagstore dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus.slave)
  );

  int unsigned tests_run;
  int unsigned tests_failed;

  // Reference state: defined only once a reset edge has been seen.
  flags_t model_flags;
  logic   model_valid;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: reset clears everything, otherwise stored = (old & ~mask) | (new & mask).
  initial begin
    model_valid = 1'b0;
    model_flags = '0;
    forever begin
      @(posedge clk);
      if (nrst === 1'b1) begin
        model_flags = '0;
        model_valid = 1'b1;
      end else if (model_valid) begin
        model_flags = (model_flags & ~bus.flag_mask) | (bus.new_flags & bus.flag_mask);
      end
    end
  end

  function automatic flags_t dut_flags();
    flags_t f;
    f[FLAG_EQ] = bus.eq;
    f[FLAG_LT] = bus.lt;
    f[FLAG_CF] = bus.cf;
    f[FLAG_OF] = bus.of;
    return f;
  endfunction

  // Per-cycle compare on the falling edge, away from the update edge.
  initial begin
    forever begin
      @(negedge clk);
      if (model_valid) begin
        tests_run++;
        if (dut_flags() !== model_flags) begin
          tests_failed++;
          $display("FAIL cycle_compare @%0t: got eq,lt,cf,of=%b expected %b",
                   $time, dut_flags(), model_flags);
        end
      end
    end
  end

  // Drive one edge's worth of inputs, then settle just after the edge.
  task automatic apply(input logic r, input flags_t m, input flags_t d);
    nrst          = r;
    bus.flag_mask = m;
    bus.new_flags = d;
    @(posedge clk);
    #1;
  endtask

  // Hand-computed literal expectation.
  task automatic check_lit(input string name, input flags_t exp);
    tests_run++;
    if (dut_flags() !== exp) begin
      tests_failed++;
      $display("FAIL %s: got eq,lt,cf,of=%b expected %b", name, dut_flags(), exp);
    end
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    nrst          = 1'b1;
    bus.flag_mask = 4'b1111;
    bus.new_flags = 4'b1010;
    #2;

    apply(1'b1, 4'b1111, 4'b1010);
    check_lit("reset", 4'b0000);

    apply(1'b0, 4'b0011, 4'bxx11);
    check_lit("partial_low", 4'b0011);

    apply(1'b0, 4'b1100, 4'b11xx);
    check_lit("partial_high", 4'b1111);

    apply(1'b0, 4'b0101, 4'b0000);
    check_lit("interleaved_clear", 4'b1010);

    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 4'b0000, 4'b1111);
      check_lit("hold_zero_mask", 4'b1010);
    end

    apply(1'b0, 4'b1111, 4'b1010);
    check_lit("full_load_1010", 4'b1010);

    apply(1'b0, 4'b1111, 4'b0101);
    check_lit("full_load_0101", 4'b0101);

    apply(1'b0, 4'b1111, 4'b1111);
    check_lit("full_load_1111", 4'b1111);

    apply(1'b1, 4'b1111, 4'b1111);
    check_lit("reset_priority", 4'b0000);

    apply(1'b0, 4'b1001, 4'b1111);
    check_lit("resume_after_reset", 4'b1001);

    apply(1'b0, 4'b0100, 4'b0000);
    check_lit("single_lt_clear", 4'b1001);

    apply(1'b0, 4'b0010, 4'b1111);
    check_lit("single_cf_set", 4'b1011);

    apply(1'b0, 4'b1000, 4'b0000);
    check_lit("single_eq_clear", 4'b0011);

    apply(1'b0, 4'b0001, 4'b1110);
    check_lit("single_of_clear", 4'b0010);

    apply(1'b0, 4'b0000, 4'b0000);
    @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
